// File: rtl/usbdev_out_pkt_writer.sv
// OUT packet writer: claims a free buffer, packs received bytes into 32-bit SRAM
// words and commits an RX descriptor on ACK, discarding the packet on rollback.
module usbdev_out_pkt_writer #(
    parameter int unsigned NumOutEps      = 2,
    parameter int unsigned MaxPktSizeByte = 64,
    parameter int unsigned BufW           = 5,
    parameter int unsigned SramAw         = 9,
    localparam int unsigned SizeW         = $clog2(MaxPktSizeByte) + 1
) (
    input  logic                          clk_48mhz_i,
    input  logic                          rst_ni,
    input  logic                          link_reset_i,
    input  logic [3:0]                    out_ep_current_i,
    input  logic                          out_ep_newpkt_i,
    input  logic                          out_ep_data_put_i,
    input  logic [7:0]                    out_ep_data_i,
    input  logic                          out_ep_acked_i,
    input  logic                          out_ep_rollback_i,
    input  logic [NumOutEps-1:0]          out_ep_setup_i,
    input  logic [NumOutEps-1:0]          rx_enable_i,
    output logic [NumOutEps-1:0]          out_ep_full_o,
    input  logic                          av_valid_i,
    input  logic [BufW-1:0]               av_buffer_i,
    output logic                          av_rready_o,
    output logic                          rx_wvalid_o,
    input  logic                          rx_wready_i,
    output logic [1+4+SizeW+BufW-1:0]     rx_wdata_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [SramAw-1:0]             mem_addr_o,
    output logic [31:0]                   mem_wdata_o
);

    localparam int unsigned IdxW     = $clog2(MaxPktSizeByte / 4);
    localparam int unsigned NumWords = MaxPktSizeByte / 4;
    localparam int unsigned MaxCnt   = MaxPktSizeByte + 2;
    localparam int unsigned EpSelW   = (NumOutEps > 1) ? $clog2(NumOutEps) : 1;
    localparam int unsigned DescW    = 1 + 4 + SizeW + BufW;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StFlush   = 2'd2;
    localparam logic [1:0] StCommit  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BufW-1:0]   buf_q, buf_d;
    logic [3:0]        ep_q, ep_d;
    logic [SizeW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              flush_sent_q, flush_sent_d;
    logic              mem_req_q, mem_req_d;
    logic [SramAw-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rx_wvalid_q, rx_wvalid_d;
    logic [DescW-1:0]  rx_wdata_q, rx_wdata_d;

    logic [1:0]        lane;
    logic              idx_in_range;
    logic [SramAw-1:0] wr_addr;
    logic [SizeW-1:0]  pkt_size;
    logic              setup_sel;

    assign lane         = byte_cnt_q[1:0];
    assign idx_in_range = byte_cnt_q[SizeW-1:2] < (SizeW-2)'(NumWords);
    assign wr_addr      = SramAw'({buf_q, byte_cnt_q[IdxW+1:2]});
    // Byte count includes the two CRC16 bytes; they never count toward the size.
    assign pkt_size     = (byte_cnt_q >= SizeW'(2)) ? byte_cnt_q - SizeW'(2) : '0;

    always_comb begin
        setup_sel = 1'b0;
        if (ep_q < 4'(NumOutEps)) setup_sel = out_ep_setup_i[ep_q[EpSelW-1:0]];
    end

    assign out_ep_full_o = ~rx_enable_i |
                           {NumOutEps{~rx_wready_i | ((state_q == StIdle) & ~av_valid_i)}};

    // RX push: rx_wvalid_o holds with stable rx_wdata_o until rx_wready_i; the
    // transfer happens in that cycle, and the buffer is popped in the same cycle.
    assign rx_wvalid_o = rx_wvalid_q;
    assign rx_wdata_o  = rx_wdata_q;
    assign av_rready_o = rx_wvalid_q & rx_wready_i;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        ep_d         = ep_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        flush_sent_d = flush_sent_q;
        mem_req_d    = mem_req_q & ~mem_gnt_i;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rx_wvalid_d  = rx_wvalid_q;
        rx_wdata_d   = rx_wdata_q;

        if (link_reset_i) begin
            state_d      = StIdle;
            flush_sent_d = 1'b0;
            rx_wvalid_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (out_ep_newpkt_i && av_valid_i) begin
                        state_d    = StCollect;
                        buf_d      = av_buffer_i;
                        ep_d       = out_ep_current_i;
                        byte_cnt_d = '0;
                    end
                end
                StCollect: begin
                    if (out_ep_newpkt_i) begin
                        // Previous transaction timed out silently: start over.
                        state_d    = av_valid_i ? StCollect : StIdle;
                        buf_d      = av_buffer_i;
                        ep_d       = out_ep_current_i;
                        byte_cnt_d = '0;
                    end else if (out_ep_rollback_i) begin
                        state_d = StIdle;
                    end else if (out_ep_acked_i) begin
                        flush_sent_d = 1'b0;
                        state_d      = (lane != 2'd0 && idx_in_range) ? StFlush : StCommit;
                    end else if (out_ep_data_put_i) begin
                        byte_cnt_d = (byte_cnt_q == SizeW'(MaxCnt)) ? byte_cnt_q
                                                                    : byte_cnt_q + SizeW'(1);
                        case (lane)
                            2'd0:    word_d = {24'h0, out_ep_data_i};
                            2'd1:    word_d[15:8]  = out_ep_data_i;
                            2'd2:    word_d[23:16] = out_ep_data_i;
                            default: word_d[31:24] = out_ep_data_i;
                        endcase
                        if (lane == 2'd3 && idx_in_range) begin
                            mem_req_d   = 1'b1;
                            mem_addr_d  = wr_addr;
                            mem_wdata_d = {out_ep_data_i, word_q[23:0]};
                        end
                    end
                end
                StFlush: begin
                    if (!flush_sent_q) begin
                        if (!mem_req_d) begin
                            mem_req_d    = 1'b1;
                            mem_addr_d   = wr_addr;
                            mem_wdata_d  = word_q;
                            flush_sent_d = 1'b1;
                        end
                    end else if (mem_gnt_i) begin
                        state_d      = StCommit;
                        flush_sent_d = 1'b0;
                    end
                end
                default: begin
                    if (rx_wvalid_q && rx_wready_i) begin
                        state_d     = StIdle;
                        rx_wvalid_d = 1'b0;
                    end
                end
            endcase

            // Descriptor is raised only once no SRAM write is outstanding.
            if (state_d == StCommit && !rx_wvalid_q && !mem_req_d) begin
                rx_wvalid_d = 1'b1;
                rx_wdata_d  = {setup_sel, ep_q, pkt_size, buf_q};
            end
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            ep_q         <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            flush_sent_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rx_wvalid_q  <= 1'b0;
            rx_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            ep_q         <= ep_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            flush_sent_q <= flush_sent_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rx_wvalid_q  <= rx_wvalid_d;
            rx_wdata_q   <= rx_wdata_d;
        end
    end

endmodule
